booth_seq_ctrl: RTL and testbench



---
 rtl/booth_seq_ctrl.sv | 98 +++++++++
 tb/tb_booth_seq_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequential radix-2 Booth signed multiplier controller.
// Performs one add/subtract/arithmetic-shift step per clock, with a
// start/busy/done handshake. in1 is the multiplicand, in2 the multiplier.
//
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   RUN   | one Booth step per cycle, busy=1
//   DONE  | out holds a fresh product, done=1 for this one cycle
module booth_seq_ctrl #(
  parameter int width = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [width-1:0]     in1,
  input  logic [width-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [2*width-1:0]   out
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  // Guard bit on M and A keeps in1 = -2^(width-1) exact.
  logic [width:0]       m_reg;
  // P = {A (width+1), Q (width), q-1 (1)}
  logic [2*width+1:0]   p_reg;
  logic [CW-1:0]        cnt;

  logic [width:0]       a_cur;
  logic [width:0]       a_new;
  logic [2*width+1:0]   p_next;

  // One Booth step: conditional add/subtract of M into A, then arithmetic shift of P.
  always_comb begin
    a_cur = p_reg[2*width+1:width+1];
    a_new = a_cur;
    case (p_reg[1:0])
      2'b01:   a_new = a_cur + m_reg;
      2'b10:   a_new = a_cur - m_reg;
      default: a_new = a_cur;
    endcase
    p_next = {a_new[width], a_new, p_reg[width:1]};
  end

  // Controller FSM with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_reg <= '0;
      p_reg <= '0;
      cnt   <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m_reg <= {in1[width-1], in1};
            p_reg <= {{(width+1){1'b0}}, in2, 1'b0};
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          p_reg <= p_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            out   <= p_next[2*width:1];
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and exhaustive bench for booth_seq_ctrl (width = 6).
module tb_booth_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  in1;
  logic [5:0]  in2;
  logic        busy;
  logic        done;
  logic [11:0] out;

  int n_chk = 0;
  int n_err = 0;

  booth_seq_ctrl #(.width(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done (bounded); returns cycles waited and busy cycles seen.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic run_mul(input string tag, input logic [5:0] a, input logic [5:0] b,
                         input logic [11:0] exp);
    int lat, nb;
    in1 = a; in2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    in1 = ~a; in2 = ~b;
    wait_done(lat, nb);
    chk_val({tag, "_lat"}, lat, 6);
    chk_val({tag, "_out"}, out, exp);
    tick();
    chk_val({tag, "_done_clr"}, done, 0);
    chk_val({tag, "_hold"}, out, exp);
  endtask

  initial begin
    int lat, nb, dc, lat_err;
    logic signed [5:0] sa, sb;
    int prod;
    logic [11:0] e;

    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    tick(); tick();
    chk_val("rst_busy", busy, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_out", out, 0);
    rst = 1'b0;
    tick();

    // Basic product with busy-width check
    in1 = 6'd3; in2 = 6'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk_val("basic_busy0", busy, 1);
    wait_done(lat, nb);
    chk_val("basic_busy_cycles", nb, 6);
    chk_val("basic_lat", lat, 6);
    chk_val("basic_out", out, 12'h00F);
    chk_val("basic_busy_at_done", busy, 0);
    tick();
    chk_val("basic_done_pulse", done, 0);
    chk_val("basic_hold", out, 12'h00F);

    // Sign cases and guard bit
    run_mul("neg3x5", 6'(-3), 6'd5, 12'hFF1);
    run_mul("31xm32", 6'd31, 6'(-32), 12'hC20);
    run_mul("0xm1", 6'd0, 6'(-1), 12'h000);
    run_mul("guard", 6'(-32), 6'(-32), 12'h400);

    // Back-to-back with start held high; input changes during busy ignored
    in1 = 6'd2; in2 = 6'd7; start = 1'b1;
    tick();
    in1 = 6'd9; in2 = 6'(-11);
    wait_done(lat, nb);
    chk_val("b2b_first", out, 12'h00E);
    in1 = 6'(-4); in2 = 6'd6;
    tick();
    in1 = 6'd17; in2 = 6'd21;
    wait_done(lat, nb);
    chk_val("b2b_gap", lat + 1, 7);
    chk_val("b2b_second", out, 12'hFE8);
    start = 1'b0;
    tick();
    chk_val("b2b_idle", busy | done, 0);

    // Reset mid-operation
    in1 = 6'd5; in2 = 6'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk_val("abort_busy", busy, 0);
    chk_val("abort_done", done, 0);
    chk_val("abort_out", out, 0);
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dc++;
      tick();
    end
    chk_val("abort_no_done", dc, 0);
    run_mul("m1xm1", 6'(-1), 6'(-1), 12'h001);

    // Exhaustive, back-to-back
    lat_err = 0;
    in1 = 6'd0; in2 = 6'd0; start = 1'b1;
    tick();
    for (int idx = 0; idx < 4096; idx++) begin
      sa = 6'(idx >> 6);
      sb = 6'(idx);
      prod = int'(sa) * int'(sb);
      e = 12'(prod);
      wait_done(lat, nb);
      if (lat != 6) lat_err++;
      chk_val("exh_out", out, e);
      if (idx < 4095) begin
        in1 = 6'((idx + 1) >> 6);
        in2 = 6'(idx + 1);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk_val("exh_latency_errs", lat_err, 0);
    chk_val("exh_idle", busy | done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
